// File: rtl/tl_tx_fc_credit_gate.sv
// Transmit-side flow-control credit gate for a single PCIe credit class.
// Holds the credit limits advertised by the link partner and the credits
// consumed so far, and grants a pending TLP only when both header and data
// credits pass the modulo gating check.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no request under evaluation
// CALC     | register required header/data credits for the request
// CHECK    | first gating check against the registered limits
// WAIT     | stalled for credits, re-checking every cycle
// GRANT    | one-cycle grant pulse, consumed counters already updated
module tl_tx_fc_credit_gate #(
    parameter int HDR_CREDS_WIDTH  = 12,
    parameter int DATA_CREDS_WIDTH = 16,
    parameter int LEN_WIDTH        = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fc_init_valid,
    input  logic                        fc_update_valid,
    input  logic [HDR_CREDS_WIDTH-1:0]  fc_hdr_limit,
    input  logic [DATA_CREDS_WIDTH-1:0] fc_data_limit,
    input  logic [1:0]                  hdr_scale,
    input  logic [1:0]                  data_scale,
    input  logic                        req_valid,
    input  logic                        req_has_data,
    input  logic [LEN_WIDTH-1:0]        req_len,
    output logic                        req_grant,
    output logic                        fc_blocked,
    output logic [HDR_CREDS_WIDTH-1:0]  hdr_consumed,
    output logic [DATA_CREDS_WIDTH-1:0] data_consumed,
    output logic                        hdr_infinite,
    output logic                        data_infinite
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CALC  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GRANT = 3'd4;

    logic [2:0]                  state;
    logic                        init_done;
    logic [HDR_CREDS_WIDTH-1:0]  hdr_limit;
    logic [DATA_CREDS_WIDTH-1:0] data_limit;
    logic [HDR_CREDS_WIDTH-1:0]  hdr_req_r;
    logic [DATA_CREDS_WIDTH-1:0] data_req_r;

    logic [HDR_CREDS_WIDTH-1:0]  hdr_mask;
    logic [HDR_CREDS_WIDTH-1:0]  hdr_half;
    logic [HDR_CREDS_WIDTH-1:0]  hdr_diff;
    logic [DATA_CREDS_WIDTH-1:0] data_mask;
    logic [DATA_CREDS_WIDTH-1:0] data_half;
    logic [DATA_CREDS_WIDTH-1:0] data_diff;
    logic [DATA_CREDS_WIDTH-1:0] data_req_calc;
    logic [LEN_WIDTH+1:0]        len_ext;
    logic                        hdr_ok;
    logic                        data_ok;
    logic                        check_pass;

    // Active field width per scale; scale 00 is treated as 01.
    always_comb begin
        hdr_mask  = {HDR_CREDS_WIDTH{1'b1}} >> (HDR_CREDS_WIDTH - 8);
        data_mask = {DATA_CREDS_WIDTH{1'b1}} >> (DATA_CREDS_WIDTH - 12);
        case (hdr_scale)
            2'b11:   hdr_mask = {HDR_CREDS_WIDTH{1'b1}};
            2'b10:   hdr_mask = {HDR_CREDS_WIDTH{1'b1}} >> (HDR_CREDS_WIDTH - 10);
            default: hdr_mask = {HDR_CREDS_WIDTH{1'b1}} >> (HDR_CREDS_WIDTH - 8);
        endcase
        case (data_scale)
            2'b11:   data_mask = {DATA_CREDS_WIDTH{1'b1}};
            2'b10:   data_mask = {DATA_CREDS_WIDTH{1'b1}} >> (DATA_CREDS_WIDTH - 14);
            default: data_mask = {DATA_CREDS_WIDTH{1'b1}} >> (DATA_CREDS_WIDTH - 12);
        endcase
        // 2^(N-1) derived from the mask so it tracks the scale.
        hdr_half  = (hdr_mask >> 1) + HDR_CREDS_WIDTH'(1);
        data_half = (data_mask >> 1) + DATA_CREDS_WIDTH'(1);
    end

    // Required data credits: ceil(len/4) with len 0 meaning the maximum length.
    always_comb begin
        len_ext = (req_len == '0) ? (LEN_WIDTH+2)'(1 << LEN_WIDTH)
                                  : (LEN_WIDTH+2)'(req_len);
        data_req_calc = req_has_data
                      ? DATA_CREDS_WIDTH'((len_ext + (LEN_WIDTH+2)'(3)) >> 2)
                      : '0;
    end

    // Modulo gating check; wrap at the full register width then mask to N.
    always_comb begin
        hdr_diff   = (hdr_limit - (hdr_consumed + hdr_req_r)) & hdr_mask;
        data_diff  = (data_limit - (data_consumed + data_req_r)) & data_mask;
        hdr_ok     = hdr_infinite || (hdr_diff <= hdr_half);
        data_ok    = data_infinite || (data_req_r == '0) || (data_diff <= data_half);
        check_pass = hdr_ok && data_ok;
    end

    assign req_grant  = (state == ST_GRANT);
    assign fc_blocked = (state == ST_WAIT);

    // Credit limits and infinite flags from InitFC / UpdateFC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_limit     <= '0;
            data_limit    <= '0;
            hdr_infinite  <= 1'b0;
            data_infinite <= 1'b0;
            init_done     <= 1'b0;
        end else if (fc_init_valid) begin
            hdr_limit     <= fc_hdr_limit & hdr_mask;
            data_limit    <= fc_data_limit & data_mask;
            hdr_infinite  <= (fc_hdr_limit == '0);
            data_infinite <= (fc_data_limit == '0);
            init_done     <= 1'b1;
        end else if (fc_update_valid && init_done) begin
            if (!hdr_infinite)  hdr_limit  <= fc_hdr_limit & hdr_mask;
            if (!data_infinite) data_limit <= fc_data_limit & data_mask;
        end
    end

    // Request sequencing and consumed-credit accounting; init aborts anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            hdr_consumed  <= '0;
            data_consumed <= '0;
            hdr_req_r     <= '0;
            data_req_r    <= '0;
        end else if (fc_init_valid) begin
            state         <= ST_IDLE;
            hdr_consumed  <= '0;
            data_consumed <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && init_done) state <= ST_CALC;
                end
                ST_CALC: begin
                    if (!req_valid) begin
                        state <= ST_IDLE;
                    end else begin
                        hdr_req_r  <= HDR_CREDS_WIDTH'(1);
                        data_req_r <= data_req_calc;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK, ST_WAIT: begin
                    if (!req_valid) begin
                        state <= ST_IDLE;
                    end else if (check_pass) begin
                        if (!hdr_infinite)
                            hdr_consumed <= (hdr_consumed + hdr_req_r) & hdr_mask;
                        if (!data_infinite)
                            data_consumed <= (data_consumed + data_req_r) & data_mask;
                        state <= ST_GRANT;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_GRANT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_tx_fc_credit_gate.sv
// Self-checking bench for tl_tx_fc_credit_gate: expected consumed values are
// queued when a request is driven and compared when the grant pulse appears.
module tb_tl_tx_fc_credit_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fc_init_valid;
    logic        fc_update_valid;
    logic [11:0] fc_hdr_limit;
    logic [15:0] fc_data_limit;
    logic [1:0]  hdr_scale;
    logic [1:0]  data_scale;
    logic        req_valid;
    logic        req_has_data;
    logic [9:0]  req_len;
    logic        req_grant;
    logic        fc_blocked;
    logic [11:0] hdr_consumed;
    logic [15:0] data_consumed;
    logic        hdr_infinite;
    logic        data_infinite;

    typedef struct packed {
        logic [11:0] hdr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    tl_tx_fc_credit_gate dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fc_init_valid  (fc_init_valid),
        .fc_update_valid(fc_update_valid),
        .fc_hdr_limit   (fc_hdr_limit),
        .fc_data_limit  (fc_data_limit),
        .hdr_scale      (hdr_scale),
        .data_scale     (data_scale),
        .req_valid      (req_valid),
        .req_has_data   (req_has_data),
        .req_len        (req_len),
        .req_grant      (req_grant),
        .fc_blocked     (fc_blocked),
        .hdr_consumed   (hdr_consumed),
        .data_consumed  (data_consumed),
        .hdr_infinite   (hdr_infinite),
        .data_infinite  (data_infinite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [11:0] h, input logic [15:0] d,
                           input logic [1:0] hs, input logic [1:0] ds);
        hdr_scale = hs; data_scale = ds;
        fc_hdr_limit = h; fc_data_limit = d;
        fc_init_valid = 1'b1;
        tick();
        fc_init_valid = 1'b0;
    endtask

    task automatic do_update(input logic [11:0] h, input logic [15:0] d);
        fc_hdr_limit = h; fc_data_limit = d;
        fc_update_valid = 1'b1;
        tick();
        fc_update_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] h, input logic [15:0] d);
        exp_t e;
        e.hdr = h; e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_hdr_consumed"}, 32'(hdr_consumed), 32'(e.hdr));
            check({tag, "_data_consumed"}, 32'(data_consumed), 32'(e.data));
        end
    endtask

    // Drive a request and wait (bounded) for its grant; exp_lat 0 skips the latency check.
    task automatic run_req(input string tag, input logic hd, input logic [9:0] len,
                           input int exp_lat);
        int  cyc;
        logic got;
        req_has_data = hd; req_len = len; req_valid = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (req_grant) got = 1'b1;
        end
        check({tag, "_grant"}, 32'(got), 32'd1);
        if (got && exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
        pop_cmp(tag);
        req_valid = 1'b0;
    endtask

    initial begin
        int grants;
        rst_n = 1'b0;
        fc_init_valid = 1'b0; fc_update_valid = 1'b0;
        fc_hdr_limit = '0; fc_data_limit = '0;
        hdr_scale = 2'b01; data_scale = 2'b01;
        req_valid = 1'b0; req_has_data = 1'b0; req_len = '0;
        repeat (3) tick();

        check("rst_grant", 32'(req_grant), 0);
        check("rst_blocked", 32'(fc_blocked), 0);
        check("rst_hdr_consumed", 32'(hdr_consumed), 0);
        check("rst_data_consumed", 32'(data_consumed), 0);
        check("rst_hdr_inf", 32'(hdr_infinite), 0);
        check("rst_data_inf", 32'(data_infinite), 0);
        rst_n = 1'b1;
        tick();

        // Pass path: hdr 4, data 8, len 16 -> 4 data credits.
        do_init(12'd4, 16'd8, 2'b01, 2'b01);
        push_exp(12'd1, 16'd4);
        run_req("pass", 1'b1, 10'd16, 3);

        // Block: len 20 needs 5 credits, 8 - 9 wraps to 4095 > 2048.
        tick();
        push_exp(12'd2, 16'd9);
        req_has_data = 1'b1; req_len = 10'd20; req_valid = 1'b1;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (req_grant) grants++;
        end
        check("block_no_grant", grants, 0);
        check("block_fc_blocked", 32'(fc_blocked), 1);
        do_update(12'd4, 16'd16);
        check("release_no_grant_at_load", 32'(req_grant), 0);
        tick();
        check("release_grant", 32'(req_grant), 1);
        pop_cmp("release");
        req_valid = 1'b0;
        tick();
        check("release_blocked_clear", 32'(fc_blocked), 0);

        // Header wrap under scale 01 (8-bit field), data infinite.
        do_init(12'd3, 16'd0, 2'b01, 2'b01);
        check("wrap_data_inf", 32'(data_infinite), 1);
        for (int i = 0; i < 255; i++) begin
            do_update(12'((i + 1) % 256), 16'd0);
            push_exp(12'(i + 1), 16'd0);
            run_req("wrap_step", 1'b0, 10'd1, 3);
        end
        do_update(12'd3, 16'd0);
        push_exp(12'd0, 16'd0);
        run_req("wrap_final", 1'b0, 10'd1, 3);

        // Both classes infinite: back-to-back len 0 requests, nothing consumed.
        do_init(12'd0, 16'd0, 2'b01, 2'b01);
        check("inf_hdr_flag", 32'(hdr_infinite), 1);
        check("inf_data_flag", 32'(data_infinite), 1);
        for (int i = 0; i < 10; i++) begin
            push_exp(12'd0, 16'd0);
            run_req("inf", 1'b1, 10'd0, (i == 0) ? 3 : 4);
        end

        // Finite data, len 0 costs 256 credits.
        do_init(12'd5, 16'h0400, 2'b01, 2'b01);
        push_exp(12'd1, 16'd256);
        run_req("len0", 1'b1, 10'd0, 3);

        // Scale 11: 0x8000 - 256 = 0x7F00 <= 0x8000.
        do_init(12'd10, 16'h8000, 2'b11, 2'b11);
        push_exp(12'd1, 16'd256);
        run_req("scale11", 1'b1, 10'd0, 3);

        // Scale 10: upper bits of 0xC100 ignored, effective limit 0x100.
        do_init(12'd10, 16'hC100, 2'b10, 2'b10);
        push_exp(12'd1, 16'd256);
        run_req("scale10", 1'b1, 10'd0, 3);

        // Abort from WAIT via init: 0x100 - 257 wraps to 0x3FFF > 0x2000.
        tick();
        req_has_data = 1'b1; req_len = 10'd4; req_valid = 1'b1;
        repeat (5) tick();
        check("abort_blocked", 32'(fc_blocked), 1);
        do_init(12'd1, 16'd1, 2'b10, 2'b10);
        req_valid = 1'b0;
        check("abort_blocked_clear", 32'(fc_blocked), 0);
        check("abort_hdr_consumed", 32'(hdr_consumed), 0);
        check("abort_data_consumed", 32'(data_consumed), 0);
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_grant) grants++;
        end
        check("abort_no_grant", grants, 0);

        // Reset asserted while in CHECK.
        do_init(12'd4, 16'd0, 2'b01, 2'b01);
        req_has_data = 1'b0; req_len = 10'd1; req_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_grant", 32'(req_grant), 0);
        check("rstmid_blocked", 32'(fc_blocked), 0);
        check("rstmid_hdr_consumed", 32'(hdr_consumed), 0);
        check("rstmid_data_consumed", 32'(data_consumed), 0);
        check("rstmid_hdr_inf", 32'(hdr_infinite), 0);
        check("rstmid_data_inf", 32'(data_infinite), 0);
        rst_n = 1'b1;
        req_valid = 1'b0;
        tick();
        check("rstmid_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
